// File: rtl/wbm_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbm_arbiter_pkg
// Description : Shared state encodings and constants for the Wishbone arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wbm_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_t;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] C_ISEL = 4'hF;

  localparam int unsigned C_TO_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/wbm_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wbm_timeout
// Description : Saturating stall counter that flags a bus transfer left
//               unanswered for TIMEOUT strobe cycles (0 disables).
// Revision    : 1.0 - initial release
// ============================================================================
module wbm_timeout
  import wbm_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic count_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam logic [C_TO_WIDTH-1:0] C_LIMIT =
    (TIMEOUT == 0) ? '0 : C_TO_WIDTH'(TIMEOUT - 1);

  logic [C_TO_WIDTH-1:0] r_cnt;

  // Fires on the TIMEOUT-th stalled strobe cycle, counting the current one.
  assign expire_o = (TIMEOUT != 0) && count_i && (r_cnt == C_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || expire_o) begin
      r_cnt <= '0;
    end else if (count_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wbm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wbm_arbiter
// Description : Two-port (instruction / data) Wishbone master arbiter with
//               registered grant, burst locking and stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wbm_arbiter
  import wbm_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned DATA_PRIORITY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  input  logic [31:0] iwbs_addr_i,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic [31:0] rdat_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_last_d;
  logic       w_stb_req;
  logic       w_resp;
  logic       w_live;
  logic       w_expire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_last_d <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_GNT_D) begin
        r_last_d <= 1'b1;
      end else if (w_next == ST_GNT_I) begin
        r_last_d <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_stb_req  = 1'b0;
    wbm_cyc_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = '0;
    wbm_addr_o = '0;
    wbm_dat_o  = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (dwbs_cyc_i && iwbs_cyc_i) begin
          w_next = ((DATA_PRIORITY != 0) || !r_last_d) ? ST_GNT_D : ST_GNT_I;
        end else if (dwbs_cyc_i) begin
          w_next = ST_GNT_D;
        end else if (iwbs_cyc_i) begin
          w_next = ST_GNT_I;
        end
      end
      ST_GNT_I: begin
        wbm_cyc_o  = iwbs_cyc_i;
        w_stb_req  = iwbs_cyc_i & iwbs_stb_i;
        wbm_sel_o  = C_ISEL;
        wbm_addr_o = iwbs_addr_i;
        if (!iwbs_cyc_i) begin
          w_next = dwbs_cyc_i ? ST_GNT_D : ST_IDLE;
        end
      end
      ST_GNT_D: begin
        wbm_cyc_o  = dwbs_cyc_i;
        w_stb_req  = dwbs_cyc_i & dwbs_stb_i;
        wbm_we_o   = dwbs_we_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
        if (!dwbs_cyc_i) begin
          w_next = iwbs_cyc_i ? ST_GNT_I : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_resp = wbm_ack_i | wbm_err_i;

  wbm_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .count_i  (w_stb_req & ~w_resp),
    .clear_i  (w_resp | (w_next != r_state)),
    .expire_o (w_expire)
  );

  // Responses reach only a requester still holding cyc; a reset cycle drops them.
  assign w_live     = wbm_cyc_o & ~rst_i;
  assign wbm_stb_o  = w_stb_req & ~w_expire;
  assign iwbs_ack_o = w_live & (r_state == ST_GNT_I) & wbm_ack_i;
  assign iwbs_err_o = w_live & (r_state == ST_GNT_I) & (wbm_err_i | w_expire);
  assign dwbs_ack_o = w_live & (r_state == ST_GNT_D) & wbm_ack_i;
  assign dwbs_err_o = w_live & (r_state == ST_GNT_D) & (wbm_err_i | w_expire);
  assign rdat_o     = (r_state == ST_IDLE) ? '0 : wbm_dat_i;

endmodule
`default_nettype wire
